shuffle_ctrl: RTL and testbench

SHUFFLE_CTRL -- requirements
Module: shuffle_ctrl

---
 rtl/shuffle_ctrl_pkg.sv | 29 ++
 rtl/card_regfile.sv | 46 ++++
 rtl/shuffle_ctrl.sv | 110 +++++++++++
 tb/tb_shuffle_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shuffle_ctrl_pkg.sv
// Shared constants, FSM state encoding and the index-scaling helper for the
// card shuffler.
package shuffle_ctrl_pkg;

   localparam int N_CARDS = 16;  // deck size, 8 pairs
   localparam int ADDR_W  = 4;   // deck index width
   localparam int VAL_W   = 3;   // card value width

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_REQ,
      ST_WAIT,
      ST_SWAP,
      ST_DONE
   } state_e;

   // Maps a 16-bit random fraction onto 0..i by taking the top bits of
   // r * (i+1). The 16x5-bit product never exceeds 20 bits.
   function automatic logic [ADDR_W-1:0] scale_index(input logic [15:0]       r,
                                                     input logic [ADDR_W-1:0] i);
      logic [4:0]  span;
      logic [19:0] prod;
      span = {1'b0, i} + 5'd1;
      prod = {4'b0, r} * {15'b0, span};
      return ADDR_W'(prod >> 16);
   endfunction

endpackage

// File: rtl/card_regfile.sv
// Deck storage: 16 x 3-bit registers with a combinational read port, a
// single-entry write port used while filling the deck and a two-entry swap
// port used while shuffling.
module card_regfile
   import shuffle_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [VAL_W-1:0]  wr_data,
   input  logic              swap_en,
   input  logic [ADDR_W-1:0] swap_a,
   input  logic [ADDR_W-1:0] swap_b,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [VAL_W-1:0]  rd_data
);

   logic [N_CARDS-1:0][VAL_W-1:0] mem_q, mem_d;

   // Next deck contents: one write or one exchange per cycle.
   always_comb begin
      // NOTE: mem_d takes the held contents first so every path assigns it and no latch is inferred.
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end else if (swap_en) begin
         // Both reads come from the old contents, so swap_a == swap_b is a no-op.
         mem_d[swap_a] = mem_q[swap_b];
         mem_d[swap_b] = mem_q[swap_a];
      end
   end

   // Deck register array with synchronous clear.
   always_ff @(posedge clk) begin
      // NOTE: the deck is a small flop array and must read back all-zero after reset, so it is cleared explicitly.
      if (!reset) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/shuffle_ctrl.sv
// Fisher-Yates shuffle controller: fills a 16-card deck with pairs 0..7,
// then walks i from 15 down to 1, requesting one random number per step
// and exchanging deck[i] with deck[j], j in 0..i.
module shuffle_ctrl
   import shuffle_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              rng_req,
   input  logic [31:0]       rng_num,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [VAL_W-1:0]  rd_data,
   output logic              busy,
   output logic              done
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;     // fill pointer in INIT, i while shuffling
   logic              busy_q, busy_d;
   logic              rng_req_q, rng_req_d;
   logic              done_q, done_d;

   logic              wr_en;
   logic              swap_en;
   logic [VAL_W-1:0]  init_val;
   logic [ADDR_W-1:0] swap_j;
   logic              unused_rng_hi;

   assign init_val      = VAL_W'(idx_q >> 1);
   assign swap_j        = scale_index(rng_num[15:0], idx_q);
   assign unused_rng_hi = ^rng_num[31:16];

   // Next-state, pointer update and registered-output decode.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wr_en   = 1'b0;
      swap_en = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_INIT;
               idx_d   = '0;
            end
         end
         ST_INIT: begin
            wr_en = 1'b1;
            if (idx_q == ADDR_W'(N_CARDS - 1)) begin
               state_d = ST_REQ;      // pointer is left at 15, the first i
            end else begin
               idx_d = idx_q + ADDR_W'(1);
            end
         end
         ST_REQ:  state_d = ST_WAIT;
         ST_WAIT: state_d = ST_SWAP;
         ST_SWAP: begin
            swap_en = 1'b1;
            if (idx_q == ADDR_W'(1)) begin
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q - ADDR_W'(1);
               state_d = ST_REQ;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d    = (state_d == ST_INIT) || (state_d == ST_REQ) ||
                  (state_d == ST_WAIT) || (state_d == ST_SWAP);
      rng_req_d = (state_d == ST_REQ);
      done_d    = (state_d == ST_DONE);
   end

   // FSM state, pointer and registered outputs; reset wins over everything.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (!reset) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         busy_q    <= 1'b0;
         rng_req_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         busy_q    <= busy_d;
         rng_req_q <= rng_req_d;
         done_q    <= done_d;
      end
   end

   assign busy    = busy_q;
   assign rng_req = rng_req_q;
   assign done    = done_q;

   card_regfile u_deck (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (idx_q),
      .wr_data (init_val),
      .swap_en (swap_en),
      .swap_a  (idx_q),
      .swap_b  (swap_j),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_shuffle_ctrl.sv
// Self-checking bench for shuffle_ctrl: the bench plays the external RNG,
// tracks each shuffle as a cycle count from the start-sampling edge, and
// recomputes the final deck with a plain Fisher-Yates over the delivered
// random numbers.
module tb_shuffle_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        rng_req;
   logic [31:0] rng_num;
   logic [3:0]  rd_addr;
   logic [2:0]  rd_data;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;

   // RNG behaviour: 0 = always zero, 1 = always all-ones, 2 = random
   int          mode;

   // reference model state
   int          n;               // 0 idle, 1..61 busy, 62 done
   bit          model_valid;
   int          model_deck [16];
   logic [31:0] rngq [$];
   int          pulses;

   always #50 clk = ~clk;

   shuffle_ctrl dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .rng_req (rng_req),
      .rng_num (rng_num),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .busy    (busy),
      .done    (done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_j(input logic [31:0] r, input int i);
      return (int'(r[15:0]) * (i + 1)) / 65536;
   endfunction

   // Compare DUT against the model, act as the RNG, then advance the model.
   initial begin
      int hist [8];
      logic [31:0] v;
      int d [16];
      rng_num     = 32'h0;
      rd_addr     = 4'h0;
      n           = 0;
      model_valid = 1'b0;
      pulses      = 0;
      forever begin
         @(negedge clk);
         if (model_valid) begin
            check("busy", {31'b0, busy}, {31'b0, (n >= 1 && n <= 61)});
            check("rng_req", {31'b0, rng_req},
                  {31'b0, (n >= 17 && n <= 59 && ((n - 17) % 3) == 0)});
            check("done", {31'b0, done}, {31'b0, (n == 62)});
            if (n == 0 || n == 62) begin
               for (int v8 = 0; v8 < 8; v8++) hist[v8] = 0;
               for (int a = 0; a < 16; a++) begin
                  rd_addr = 4'(a);
                  #1;
                  check($sformatf("deck[%0d]", a), {29'b0, rd_data}, 32'(model_deck[a]));
                  if (!$isunknown(rd_data)) hist[rd_data]++;
               end
               if (n == 62)
                  for (int v8 = 0; v8 < 8; v8++)
                     check($sformatf("pair count of %0d", v8), 32'(hist[v8]), 32'd2);
            end
            if (rng_req === 1'b1) begin
               pulses++;
               v = (mode == 0) ? 32'h0 : (mode == 1) ? 32'hFFFF_FFFF : $urandom;
               rng_num = v;
               rngq.push_back(v);
            end
         end
         // advance to what the DUT should show after the coming edge
         if (reset !== 1'b1) begin
            n = 0;
            model_valid = 1'b1;
            for (int k = 0; k < 16; k++) model_deck[k] = 0;
            rngq.delete();
            pulses = 0;
         end else if (model_valid) begin
            if (n == 0) begin
               if (start === 1'b1) begin
                  n = 1;
                  rngq.delete();
                  pulses = 0;
               end
            end else if (n == 62) begin
               n = 0;
            end else begin
               n++;
               if (n == 62) begin
                  check("rng values delivered", 32'(rngq.size()), 32'd15);
                  for (int k = 0; k < 16; k++) d[k] = k / 2;
                  for (int s = 0; s < 15; s++) begin
                     int i, j, t;
                     i = 15 - s;
                     j = model_j((s < rngq.size()) ? rngq[s] : 32'h0, i);
                     t = d[i]; d[i] = d[j]; d[j] = t;
                  end
                  model_deck = d;
               end
            end
         end
      end
   end

   task automatic tick(input int cnt);
      repeat (cnt) @(posedge clk);
      #1;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 1;
      while (done !== 1'b1 && cyc < 200) begin
         tick(1);
         cyc++;
      end
   endtask

   initial begin
      int cyc, p, c;
      int lit_hi [16];
      int lit_lo [16];
      reset = 1'b0;
      start = 1'b0;
      mode  = 1;
      for (int k = 0; k < 16; k++) begin
         lit_hi[k] = k / 2;
         lit_lo[k] = (k == 0 || k == 15) ? 0 : (k + 1) / 2;
      end

      // pin the index scaling of the model
      check("model_j ffff i=15", 32'(model_j(32'hFFFF_FFFF, 15)), 32'd15);
      check("model_j 8000 i=15", 32'(model_j(32'h0000_8000, 15)), 32'd8);
      check("model_j upper ignored", 32'(model_j(32'h0001_0000, 15)), 32'd0);
      check("model_j ffff i=1", 32'(model_j(32'h0000_FFFF, 1)), 32'd1);

      tick(3);
      reset = 1'b1;
      tick(2);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);

      // all-ones RNG: identity shuffle
      mode = 1;
      start_pulse();
      wait_done(cyc);
      check("latency all-ones", 32'(cyc), 32'd62);
      check("pulses all-ones", 32'(pulses), 32'd15);
      for (int k = 0; k < 16; k++)
         check($sformatf("model all-ones deck[%0d]", k), 32'(model_deck[k]), 32'(lit_hi[k]));
      tick(3);

      // zero RNG: rotation through slot 0
      mode = 0;
      start_pulse();
      wait_done(cyc);
      check("latency zero", 32'(cyc), 32'd62);
      check("pulses zero", 32'(pulses), 32'd15);
      for (int k = 0; k < 16; k++)
         check($sformatf("model zero deck[%0d]", k), 32'(model_deck[k]), 32'(lit_lo[k]));
      tick(3);

      // reset in the cycle after the 5th rng_req aborts the shuffle
      mode = 2;
      start_pulse();
      p = 0;
      c = 0;
      while (p < 5 && c < 200) begin
         if (rng_req === 1'b1) p++;
         if (p < 5) begin
            tick(1);
            c++;
         end
      end
      check("reached 5th rng_req", 32'(p), 32'd5);
      tick(1);
      reset = 1'b0;
      tick(1);
      check("abort busy", {31'b0, busy}, 32'd0);
      check("abort done", {31'b0, done}, 32'd0);
      reset = 1'b1;
      tick(2);
      start_pulse();
      wait_done(cyc);
      check("latency after abort", 32'(cyc), 32'd62);
      tick(3);

      // extra starts while busy and during DONE are ignored
      start = 1'b1;
      tick(1);
      start = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 200) begin
         if (cyc == 10 || cyc == 40) start = 1'b1;
         tick(1);
         start = 1'b0;
         cyc++;
      end
      check("latency with extra starts", 32'(cyc), 32'd62);
      check("pulses with extra starts", 32'(pulses), 32'd15);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(2);
      check("start in DONE ignored", {31'b0, busy}, 32'd0);

      // 100 back-to-back shuffles with start held high
      start = 1'b1;
      tick(1);
      wait_done(cyc);
      check("first back-to-back latency", 32'(cyc), 32'd62);
      for (int s = 1; s < 100; s++) begin
         c = 0;
         do begin
            tick(1);
            c++;
         end while (done !== 1'b1 && c < 200);
         check($sformatf("spacing %0d", s), 32'(c), 32'd63);
      end
      start = 1'b0;
      tick(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule
